// File: rtl/cache_arbiter_pkg.sv
// Shared constants for the two-port cache arbiter: FSM encoding, port indices and defaults.
package cache_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;
    localparam arb_state_t GAP   = 2'd3;

    localparam logic P_IF   = 1'b0;
    localparam logic P_DATA = 1'b1;

    localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester buses of both ports plus the cache-side lines, seen from the arbiter (slave)
// and from the requesters/cache (master).
interface cache_arbiter_if #(
    parameter int d_width = 8,
    parameter int a_width = 8
);
    logic               req0;
    logic               req1;
    logic               rw0;
    logic               rw1;
    logic [a_width-1:0] addr0;
    logic [a_width-1:0] addr1;
    logic [d_width-1:0] wdata0;
    logic [d_width-1:0] wdata1;
    logic               ack0;
    logic               ack1;
    logic               err0;
    logic               err1;
    logic [d_width-1:0] rdata0;
    logic [d_width-1:0] rdata1;
    logic [a_width-1:0] c_addr;
    logic [d_width-1:0] c_wdata;
    logic               c_rw;
    logic               c_ce;
    logic [d_width-1:0] c_rdata;
    logic               c_odv;
    logic               busy;

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, c_rdata, c_odv,
        output ack0, ack1, err0, err1, rdata0, rdata1, c_addr, c_wdata, c_rw, c_ce, busy
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, c_rdata, c_odv,
        input  ack0, ack1, err0, err1, rdata0, rdata1, c_addr, c_wdata, c_rw, c_ce, busy
    );

endinterface

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that did not win last.
module rr_pick2
    import cache_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : (req1 ? P_DATA : P_IF);

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache between the fetch port (0) and the data port (1),
// with a one-cycle chip-enable gap between transactions and a watchdog abort.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int timeout = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           clr,
    cache_arbiter_if.slave bus
);

    localparam int CW = $clog2(timeout);

    arb_state_t         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [CW-1:0]      wdCnt_q, wdCnt_d;
    logic [a_width-1:0] cAddr_q, cAddr_d;
    logic [d_width-1:0] cWdata_q, cWdata_d;
    logic               cRw_q, cRw_d;
    logic               cCe_q;
    logic               busy_q;
    logic [d_width-1:0] rdata0_q, rdata0_d;
    logic [d_width-1:0] rdata1_q, rdata1_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err0_q, err0_d;
    logic               err1_q, err1_d;
    logic               pickValid;
    logic               pickWinner;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .valid  (pickValid),
        .winner (pickWinner)
    );

    // The c_* registers double as the latched copy of the granted request.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        wdCnt_d  = wdCnt_q;
        cAddr_d  = cAddr_q;
        cWdata_d = cWdata_q;
        cRw_d    = cRw_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    gnt_d    = pickWinner;
                    last_d   = pickWinner;
                    cAddr_d  = (pickWinner == P_DATA) ? bus.addr1 : bus.addr0;
                    cRw_d    = (pickWinner == P_DATA) ? bus.rw1 : bus.rw0;
                    cWdata_d = cRw_d ? '0 : ((pickWinner == P_DATA) ? bus.wdata1 : bus.wdata0);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wdCnt_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.c_odv) begin
                    if (cRw_q) begin
                        if (gnt_q == P_DATA) rdata1_d = bus.c_rdata;
                        else                 rdata0_d = bus.c_rdata;
                    end
                    ack0_d  = (gnt_q == P_IF);
                    ack1_d  = (gnt_q == P_DATA);
                    state_d = GAP;
                end else if (wdCnt_q == CW'(timeout - 1)) begin
                    ack0_d  = (gnt_q == P_IF);
                    ack1_d  = (gnt_q == P_DATA);
                    err0_d  = (gnt_q == P_IF);
                    err1_d  = (gnt_q == P_DATA);
                    state_d = GAP;
                end else begin
                    wdCnt_d = wdCnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Chip enable and busy are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            wdCnt_q  <= '0;
            cAddr_q  <= '0;
            cWdata_q <= '0;
            cRw_q    <= 1'b0;
            cCe_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            wdCnt_q  <= wdCnt_d;
            cAddr_q  <= cAddr_d;
            cWdata_q <= cWdata_d;
            cRw_q    <= cRw_d;
            cCe_q    <= (state_d == ISSUE) || (state_d == WAIT);
            busy_q   <= (state_d != IDLE);
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.c_addr  = cAddr_q;
    assign bus.c_wdata = cWdata_q;
    assign bus.c_rw    = cRw_q;
    assign bus.c_ce    = cCe_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: a behavioural cache with programmable latency plus a
// transaction-level reference model of grant order, read data and acknowledge timing.
module tb_cache_arbiter;
    import cache_arb_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int TMO = 32;

    logic clk = 1'b0;
    logic clr;

    cache_arbiter_if #(.d_width(DW), .a_width(AW)) bus ();

    cache_arbiter #(.d_width(DW), .a_width(AW), .timeout(TMO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mem    [256];
    logic [7:0] refMem [256];
    logic [7:0] refRdata [2];
    logic       refLast;
    int         cacheLat;
    bit         stalePulse;
    int         ceCnt;

    logic       opRw    [2];
    logic [7:0] opAddr  [2];
    logic [7:0] opWdata [2];

    typedef struct {
        int         cycles;
        logic       ack0, ack1, err0, err1;
        logic [7:0] addr, wdata;
        logic       rw;
    } obs_t;

    // Cache model: odv is seen at the (cacheLat+1)-th edge after ce rises; 0 means never.
    always @(negedge clk) begin
        bus.c_odv   = 1'b0;
        bus.c_rdata = 8'($urandom);
        if (bus.c_ce !== 1'b1) begin
            ceCnt = 0;
        end else begin
            ceCnt++;
            if (stalePulse && ceCnt == 1) begin
                bus.c_odv   = 1'b1;
                bus.c_rdata = 8'hEE;
            end else if (cacheLat != 0 && ceCnt == cacheLat + 1) begin
                bus.c_odv = 1'b1;
                if (bus.c_rw) bus.c_rdata = mem[bus.c_addr];
                else          mem[bus.c_addr] = bus.c_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input int p, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
        opRw[p] = rw; opAddr[p] = addr; opWdata[p] = wd;
        if (p == 0) begin bus.rw0 = rw; bus.addr0 = addr; bus.wdata0 = wd; end
        else        begin bus.rw1 = rw; bus.addr1 = addr; bus.wdata1 = wd; end
    endtask

    task automatic randOp(input int p);
        setOp(p, 1'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));
    endtask

    function automatic logic [7:0] rdataOf(input int p);
        return (p == 0) ? bus.rdata0 : bus.rdata1;
    endfunction

    task automatic waitAck(output obs_t o);
        o.cycles = -1; o.ack0 = 0; o.ack1 = 0; o.err0 = 0; o.err1 = 0;
        o.addr = 0; o.wdata = 0; o.rw = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.c_ce === 1'b1) begin
                o.addr = bus.c_addr; o.wdata = bus.c_wdata; o.rw = bus.c_rw;
            end
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                o.cycles = i;
                o.ack0 = bus.ack0; o.ack1 = bus.ack1; o.err0 = bus.err0; o.err1 = bus.err1;
                return;
            end
        end
    endtask

    task automatic applyReset();
        clr = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(); tick();
        clr = 1'b0;
        refLast = 1'b1; refRdata[0] = 8'h00; refRdata[1] = 8'h00;
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(); tick();
        compared++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.c_rw, bus.c_ce, bus.busy} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: observed %b, required 0000000",
                     {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.c_rw, bus.c_ce, bus.busy});
        end
        compared++;
        if ({bus.rdata0, bus.rdata1, bus.c_addr, bus.c_wdata} !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: observed %h, required 0",
                     {bus.rdata0, bus.rdata1, bus.c_addr, bus.c_wdata});
        end
        clr = 1'b0;
        refLast = 1'b1; refRdata[0] = 8'h00; refRdata[1] = 8'h00;
        tick();
        compared++;
        if ({bus.c_ce, bus.busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: observed %b, required 00", {bus.c_ce, bus.busy});
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        mem[8'h10] = 8'hA5; refMem[8'h10] = 8'hA5;
        cacheLat = 1;
        bus.req0 = 1'b1;
        setOp(0, 1'b1, 8'h10, 8'h77);
        waitAck(o);
        bus.req0 = 1'b0;
        compared++;
        if (o.cycles != cacheLat + 2) begin
            mismatched++;
            $display("[TB] FAIL single_latency: observed %0d, required %0d", o.cycles, cacheLat + 2);
        end
        compared++;
        if ({o.ack0, o.ack1, o.err0, o.err1} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL single_ack: observed %b, required 1000", {o.ack0, o.ack1, o.err0, o.err1});
        end
        compared++;
        if (bus.rdata0 !== refMem[8'h10]) begin
            mismatched++;
            $display("[TB] FAIL single_rdata: observed %h, required %h", bus.rdata0, refMem[8'h10]);
        end
        compared++;
        if ({o.addr, o.rw, o.wdata} !== {8'h10, 1'b1, 8'h00}) begin
            mismatched++;
            $display("[TB] FAIL single_issue: observed %h, required %h", {o.addr, o.rw, o.wdata}, {8'h10, 1'b1, 8'h00});
        end
        compared++;
        if (bus.c_ce !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_gap_ce: observed %b, required 0", bus.c_ce);
        end
        refRdata[0] = refMem[8'h10]; refLast = 1'b0;
        tick();
        compared++;
        if ({bus.ack0, bus.busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL single_pulse: observed %b, required 00", {bus.ack0, bus.busy});
        end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        logic win;
        applyReset();
        cacheLat = 1;
        setOp(0, 1'b1, 8'h20, 8'h99);
        setOp(1, 1'b0, 8'h30, 8'h5C);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        win = ~refLast;
        waitAck(o);
        bus.req0 = 1'b0;
        compared++;
        if ({o.ack1, o.ack0} !== {win, ~win} || o.cycles != cacheLat + 2) begin
            mismatched++;
            $display("[TB] FAIL sim_first: observed ack %b in %0d, required %b in %0d",
                     {o.ack1, o.ack0}, o.cycles, {win, ~win}, cacheLat + 2);
        end
        compared++;
        if (bus.rdata0 !== refMem[8'h20] || o.wdata !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL sim_read: observed rdata %h wdata %h, required %h and 00",
                     bus.rdata0, o.wdata, refMem[8'h20]);
        end
        refRdata[0] = refMem[8'h20]; refLast = win;
        win = 1'b1;
        waitAck(o);
        bus.req1 = 1'b0;
        compared++;
        if ({o.ack1, o.ack0, o.err1} !== 3'b100 || o.cycles != cacheLat + 3) begin
            mismatched++;
            $display("[TB] FAIL sim_second: observed %b in %0d, required 100 in %0d",
                     {o.ack1, o.ack0, o.err1}, o.cycles, cacheLat + 3);
        end
        compared++;
        if ({o.rw, o.wdata, o.addr} !== {1'b0, 8'h5C, 8'h30}) begin
            mismatched++;
            $display("[TB] FAIL sim_write_lines: observed %h, required %h", {o.rw, o.wdata, o.addr}, {1'b0, 8'h5C, 8'h30});
        end
        refMem[8'h30] = 8'h5C; refLast = win;
        compared++;
        if (bus.rdata1 !== refRdata[1] || mem[8'h30] !== refMem[8'h30]) begin
            mismatched++;
            $display("[TB] FAIL sim_write_effect: observed rdata1 %h mem %h, required %h and %h",
                     bus.rdata1, mem[8'h30], refRdata[1], refMem[8'h30]);
        end
        tick();
    endtask

    task automatic test_fairness();
        obs_t o;
        logic win;
        int expCyc;
        randOp(0); randOp(1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cacheLat = $urandom_range(1, 4);
            expCyc = cacheLat + ((k == 0) ? 2 : 3);
            win = ~refLast;
            waitAck(o);
            compared++;
            if ({o.ack1, o.ack0} !== {win, ~win} || o.cycles != expCyc || (o.err0 | o.err1) !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL fair_grant%0d: observed ack %b err %b in %0d, required %b 00 in %0d",
                         k, {o.ack1, o.ack0}, {o.err1, o.err0}, o.cycles, {win, ~win}, expCyc);
            end
            if (opRw[win]) refRdata[win] = refMem[opAddr[win]];
            else           refMem[opAddr[win]] = opWdata[win];
            compared++;
            if (rdataOf(int'(win)) !== refRdata[win]) begin
                mismatched++;
                $display("[TB] FAIL fair_rdata%0d: observed %h, required %h", k, rdataOf(int'(win)), refRdata[win]);
            end
            refLast = win;
            randOp(int'(win));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_miss();
        obs_t o;
        logic [7:0] a;
        a = 8'($urandom);
        mem[a] = 8'h3C; refMem[a] = 8'h3C;
        cacheLat = 11; stalePulse = 1'b1;
        setOp(0, 1'b1, a, 8'h11);
        bus.req0 = 1'b1;
        waitAck(o);
        bus.req0 = 1'b0;
        stalePulse = 1'b0;
        compared++;
        if (o.cycles != cacheLat + 2 || {o.ack1, o.ack0, o.err0} !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL miss_ack: observed %b in %0d, required 010 in %0d",
                     {o.ack1, o.ack0, o.err0}, o.cycles, cacheLat + 2);
        end
        compared++;
        if (bus.rdata0 !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL miss_rdata: observed %h, required 3c", bus.rdata0);
        end
        refRdata[0] = 8'h3C; refLast = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [7:0] a;
        cacheLat = 0;
        setOp(1, 1'b1, 8'($urandom), 8'h22);
        bus.req1 = 1'b1;
        waitAck(o);
        bus.req1 = 1'b0;
        compared++;
        if (o.cycles != TMO + 2 || {o.ack1, o.ack0, o.err1, o.err0} !== 4'b1010) begin
            mismatched++;
            $display("[TB] FAIL timeout_ack: observed %b in %0d, required 1010 in %0d",
                     {o.ack1, o.ack0, o.err1, o.err0}, o.cycles, TMO + 2);
        end
        compared++;
        if (bus.rdata1 !== refRdata[1]) begin
            mismatched++;
            $display("[TB] FAIL timeout_rdata: observed %h, required %h", bus.rdata1, refRdata[1]);
        end
        refLast = 1'b1;
        tick();
        compared++;
        if ({bus.ack1, bus.err1, bus.c_ce} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL timeout_pulse: observed %b, required 000", {bus.ack1, bus.err1, bus.c_ce});
        end
        cacheLat = 1;
        a = 8'($urandom);
        setOp(1, 1'b1, a, 8'h33);
        bus.req1 = 1'b1;
        waitAck(o);
        bus.req1 = 1'b0;
        compared++;
        if (o.cycles != cacheLat + 2 || {o.ack1, o.err1} !== 2'b10 || bus.rdata1 !== refMem[a]) begin
            mismatched++;
            $display("[TB] FAIL timeout_recover: observed %b rdata %h in %0d, required 10 %h in %0d",
                     {o.ack1, o.err1}, bus.rdata1, o.cycles, refMem[a], cacheLat + 2);
        end
        refRdata[1] = refMem[a];
        tick();
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        int stray;
        cacheLat = 0;
        setOp(0, 1'b1, 8'($urandom), 8'h44);
        bus.req0 = 1'b1;
        tick(); tick(); tick(); tick();
        compared++;
        if ({bus.c_ce, bus.busy} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_active: observed %b, required 11", {bus.c_ce, bus.busy});
        end
        clr = 1'b1; bus.req0 = 1'b0;
        tick();
        compared++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.c_ce, bus.busy, bus.c_rw,
             bus.rdata0, bus.rdata1, bus.c_addr, bus.c_wdata} !== 39'h0) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_outputs: observed %h, required 0",
                     {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.c_ce, bus.busy, bus.c_rw,
                      bus.rdata0, bus.rdata1, bus.c_addr, bus.c_wdata});
        end
        clr = 1'b0;
        refLast = 1'b1; refRdata[0] = 8'h00; refRdata[1] = 8'h00;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ((bus.ack0 | bus.ack1 | bus.err0 | bus.err1 | bus.c_ce) !== 1'b0) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_quiet: observed %0d stray cycles, required 0", stray);
        end
        cacheLat = 1;
        randOp(0); randOp(1);
        setOp(0, 1'b1, opAddr[0], opWdata[0]);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        waitAck(o);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        compared++;
        if ({o.ack1, o.ack0} !== 2'b01 || o.cycles != cacheLat + 2 || bus.rdata0 !== refMem[opAddr[0]]) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_tie: observed %b rdata %h in %0d, required 01 %h in %0d",
                     {o.ack1, o.ack0}, bus.rdata0, o.cycles, refMem[opAddr[0]], cacheLat + 2);
        end
        refRdata[0] = refMem[opAddr[0]]; refLast = 1'b0;
        tick();
    endtask

    task automatic test_random();
        obs_t o;
        logic [1:0] r;
        logic win;
        int expCyc, gap;
        gap = 1;
        for (int it = 0; it < 24; it++) begin
            r = 2'($urandom_range(1, 3));
            randOp(0); randOp(1);
            cacheLat = $urandom_range(1, 12);
            expCyc = cacheLat + 2 + ((gap == 0) ? 1 : 0);
            win = (r == 2'b11) ? ~refLast : r[1];
            bus.req0 = r[0]; bus.req1 = r[1];
            waitAck(o);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            if (opRw[win]) refRdata[win] = refMem[opAddr[win]];
            else           refMem[opAddr[win]] = opWdata[win];
            refLast = win;
            compared++;
            if ({o.ack1, o.ack0, o.err1, o.err0} !== {win, ~win, 2'b00} || o.cycles != expCyc) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_ack: observed %b in %0d, required %b in %0d",
                         it, {o.ack1, o.ack0, o.err1, o.err0}, o.cycles, {win, ~win, 2'b00}, expCyc);
            end
            compared++;
            if ({o.addr, o.rw, o.wdata} !== {opAddr[win], opRw[win], opRw[win] ? 8'h00 : opWdata[win]}) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_issue: observed %h, required %h", it, {o.addr, o.rw, o.wdata},
                         {opAddr[win], opRw[win], opRw[win] ? 8'h00 : opWdata[win]});
            end
            compared++;
            if ({bus.rdata1, bus.rdata0} !== {refRdata[1], refRdata[0]}) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_rdata: observed %h, required %h", it,
                         {bus.rdata1, bus.rdata0}, {refRdata[1], refRdata[0]});
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
        end
        tick();
    endtask

    initial begin
        clr = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.rw0 = 1'b1; bus.rw1 = 1'b1;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00;
        bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
        bus.c_odv = 1'b0; bus.c_rdata = 8'h00;
        cacheLat = 1; stalePulse = 1'b0; ceCnt = 0; refLast = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'($urandom);
            refMem[i] = mem[i];
        end
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_miss();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single `cache` instance between the instruction-fetch port (port 0) and the data port (port 1). It grants one requester at a time using round-robin, and drives the cache's address, data, rw and chip-enable lines from latched copies of the request. It waits for the cache's output-data-valid pulse, returns read data and an acknowledge to the winner, and enforces a one-cycle chip-enable gap between transactions. A watchdog aborts any transaction the cache never completes.

## Interface
- `d_width`, 8: data width; matches the cache's `d_width`.
- `a_width`, 8: address width; matches the cache's `a_width`.
- `timeout`, 32: maximum WAIT cycles before abort; must be ≥ 2.
- `clk`  in  1  clock; all state changes on posedge.
- `clr`  in  1  reset: synchronous, active-high.
- `req0`, `req1`  in  1  request from port 0 / port 1.
- `rw0`, `rw1`  in  1  1 = read, 0 = write (cache convention).
- `addr0`, `addr1`  in  a_width  request address.
- `wdata0`, `wdata1`  in  d_width  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  one-cycle pulse, coincident with ack, on timeout abort.
- `rdata0`, `rdata1`  out  d_width  read data; held until that port's next read ack.
- `c_addr`  out  a_width  address to cache `addr_in`.
- `c_wdata`  out  d_width  write data to the cache data bus driver.
- `c_rw`  out  1  to cache `rw_in`.
- `c_ce`  out  1  to cache `ce_in`.
- `c_rdata`  in  d_width  cache data bus, sampled on read completion.
- `c_odv`  in  1  cache `odv`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Every output is registered. Reset value of every output is 0. After reset, `last` = 1, so port 0 wins the first tie.
- **IDLE** (`c_ce`=0)
  - If any request is sampled high, pick the winner:
    - single request: that port;
    - both requests: the port ≠ `last`.
  - Latch the winner's addr/rw/wdata, set `gnt` and `last` to the winner, go to ISSUE.
- **ISSUE** (`c_ce`=1, latched values on the `c_*` lines)
  - `c_odv` is ignored in this cycle (stale-pulse guard).
  - Clear the watchdog counter, go to WAIT.
- **WAIT** (`c_ce`=1, values held)
  - `c_odv`=1 at a posedge:
    - read: capture `c_rdata` into `rdata[gnt]`;
    - raise `ack[gnt]`, go to GAP.
  - Otherwise the counter increments. When it reaches `timeout`-1 without `c_odv`, raise `ack[gnt]` and `err[gnt]`, leave `rdata` unchanged, go to GAP.
- **GAP** (`c_ce`=0)
  - The ack/err pulse is visible in this cycle.
  - Dropping `ce` returns the cache FSM to its idle state and clears `odv`.
  - Go to IDLE. A new grant is possible on the next edge.
- Requester rules:
  - Hold `req` and operands stable until ack.
  - `req` may drop in the ack cycle.
  - `req` still high in the ack cycle is a new request.
  - Operand changes after grant are ignored (latched copy).
  - `req` withdrawn before ack: the transaction still completes and ack still pulses.
- Writes: `rdata` is not updated. `c_wdata` is driven only while `c_rw`=0; it is 0 otherwise.
- `clr`=1 mid-transaction: abandon the transaction, no ack/err, `c_ce`=0 on the following cycle, state returns to IDLE.
- Watchdog counter width is `$clog2(timeout)`. It saturates and never wraps.

## Timing
- Request sampled at edge N (IDLE).
- `c_ce` rises after N. ISSUE is the cycle N..N+1; WAIT starts at N+1.
- Cache hit:
  - `c_odv` sampled at N+2;
  - ack high in cycle N+2..N+3;
  - next grant at edge N+4.
- Cache miss: `c_odv` arrives 10–12 cycles later. Ack follows one cycle after `c_odv` is sampled.
- Timeout: ack+err high in the cycle after WAIT has lasted `timeout` cycles.
- Minimum spacing between grants: 4 cycles.
- Two back-to-back competing requesters alternate strictly: 0,1,0,1…

## Structure
- Shared package `cache_arb_pkg` holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT=2, GAP=3;
  - port index constants: P_IF=0, P_DATA=1;
  - default `timeout`.
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs: `req0`, `req1`, `last`. Outputs: `valid`, `winner`.
- Everything else (FSM, operand latches, watchdog, output registers) lives in `cache_arbiter`.

## Test plan
- Reset then a single read: port 0 reads addr 0x10; cache model hits with data 0xA5 → `ack0` asserted 3 cycles after grant, `rdata0`=0xA5, `c_ce` low the next cycle.
- Simultaneous requests: port 0 reads 0x20, port 1 writes 0x5C to 0x30 → port 0 served first; port 1 `c_rw`=0 with `c_wdata`=0x5C; `rdata1` unchanged.
- Fairness: both ports hold `req` for 8 transactions → grant order 0,1,0,1,0,1,0,1; no port receives two consecutive acks.
- Miss latency: cache model delays `c_odv` by 11 cycles, read data 0x3C → ack after `c_odv`, `rdata`=0x3C, `err`=0.
- Timeout: cache model never asserts `c_odv`, `timeout`=32 → `ack`+`err` pulse after 32 WAIT cycles; `rdata` unchanged; the next request is served normally.
- Reset mid-WAIT: assert `clr` on WAIT cycle 3 → no ack/err; `c_ce`=0 next cycle; all outputs 0; the first post-reset tie goes to port 0.
